// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types and constants.
// Contents: uart_rx_state_t state enum, default bit-cell length, data width.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} uart_rx_state_t;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 104;
    localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if: byte hand-off between the UART receiver and its consumer.
// Signals: rx_byte, byte_available, frame_error, overrun, parity_error (receiver to consumer),
// byte_ack (consumer to receiver). Modports: master = receiver, slave = consumer.
interface uart_rx_framer_if;
    logic [7:0] rx_byte;
    logic       byte_available;
    logic       byte_ack;
    logic       frame_error;
    logic       overrun;
    logic       parity_error;
    modport master (output rx_byte, byte_available, frame_error, overrun, parity_error, input byte_ack);
    modport slave (input rx_byte, byte_available, frame_error, overrun, parity_error, output byte_ack);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an asynchronous input, both flops reset to 1.
// Ports: clk, rst (async active-high), i_async (raw input), o_sync (synchronised output).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);
    logic r_meta;
    logic r_sync;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end
    assign o_sync = r_sync;
endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with 3-sample majority voting.
// Ports: clk, rst (async active-high), rx (raw serial input, idle high),
// bus (uart_rx_framer_if.master: rx_byte, byte_available, byte_ack, frame_error, overrun, parity_error).
// Parameter: CLKS_PER_BIT (>= 8) clock cycles per bit cell.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    uart_rx_framer_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_S0 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_S1 = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_DEC = CW'(CLKS_PER_BIT / 2 + 1);
    uart_rx_state_t r_state;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_smp;
    logic [BW-1:0]  r_bit;
    logic [7:0]     r_shift;
    logic [7:0]     r_rx_byte;
    logic           r_avail;
    logic           r_fe;
    logic           r_ovr;
    logic           w_rxs;
    logic           w_last;
    logic           w_dec;
    logic           w_maj;
    logic           w_perr;
    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx),
        .o_sync  (w_rxs)
    );
    assign w_last = r_cnt == C_LAST;
    assign w_dec  = r_cnt == C_DEC;
    // the third sample is the live synchronised input at the decision offset
    assign w_maj  = (r_smp[0] & r_smp[1]) | (w_rxs & (r_smp[0] | r_smp[1]));
`ifdef UART_RX_PARITY_EN
    logic r_par_err;
    logic r_pe;
    assign w_perr = r_par_err;
    assign bus.parity_error = r_pe;
`else
    assign w_perr = 1'b0;
    assign bus.parity_error = 1'b0;
`endif
    // IDLE is always at least one cycle, which also zeroes the cell counter before START
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_smp     <= '1;
            r_bit     <= '0;
            r_shift   <= '0;
            r_rx_byte <= '0;
            r_avail   <= 1'b0;
            r_fe      <= 1'b0;
            r_ovr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
            r_pe      <= 1'b0;
`endif
        end else begin
            r_fe  <= 1'b0;
            r_ovr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pe  <= 1'b0;
`endif
            if (bus.byte_ack) r_avail <= 1'b0;
            r_cnt <= (r_state == IDLE || r_state == WAIT_IDLE || w_last) ? '0 : r_cnt + 1'b1;
            if (r_cnt == C_S0 || r_cnt == C_S1) r_smp <= {r_smp[0], w_rxs};
            case (r_state)
                IDLE: if (!w_rxs) r_state <= START;
                START: begin
                    if (w_dec && w_maj) r_state <= IDLE;
                    else if (w_last) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shifting in from the top leaves it in bit 0
                    if (w_dec) r_shift <= {w_maj, r_shift[7:1]};
                    if (w_last) begin
                        r_bit <= r_bit + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (&r_bit) r_state <= PARITY;
`else
                        if (&r_bit) r_state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_dec) r_par_err <= w_maj != ^r_shift;
                    if (w_last) r_state <= STOP;
                end
`endif
                STOP: begin
                    // leave mid-stop so a back-to-back start edge is not missed
                    if (w_dec) begin
                        if (w_maj && !w_perr) begin
                            r_rx_byte <= r_shift;
                            r_avail   <= 1'b1;
                            r_ovr     <= r_avail && !bus.byte_ack;
                            r_state   <= IDLE;
                        end else begin
                            r_fe    <= !w_maj;
`ifdef UART_RX_PARITY_EN
                            r_pe    <= w_perr;
`endif
                            r_state <= w_maj ? IDLE : WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: if (w_rxs) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.rx_byte        = r_rx_byte;
    assign bus.byte_available = r_avail;
    assign bus.frame_error    = r_fe;
    assign bus.overrun        = r_ovr;
endmodule
